book_delta_publisher: RTL
=========================

// Module: book_delta_publisher
// PURPOSE
//  Downstream of Order_Book. On each orderbook_ready pulse, snapshots all BID/ASK levels and compares them
//  with the last published image. Serializes only the changed levels as 64-bit words on a valid/ready
//  stream toward the outbound feed/FIFO, then emits one trailer word per update burst.
// PARAMETERS
//  SECURITY_ID  32'd123  instrument id copied into every trailer word
//  DEPTH        10       levels per side; matches the Order_Book depth parameter (1..16)
// PORTS
//  clk              in   1          system clock, rising edge
//  reset_n          in   1          asynchronous, active-low reset
//  orderbook_ready  in   1          1-cycle pulse: book levels updated and stable
//  bid_levels       in   DEPTH*88   level i = bits [88*i+87 -: 88], 0 = best bid
//  ask_levels       in   DEPTH*88   level i = bits [88*i+87 -: 88], 0 = best ask
//  out_data         out  64         serialized word
//  out_valid        out  1          out_data valid
//  out_ready        in   1          consumer accepts when out_valid && out_ready
//  out_last         out  1          marks trailer word (end of burst)
//  busy             out  1          not IDLE
//  coalesced_cnt    out  16         saturating count of pulses merged while busy
// BEHAVIOUR
//  - Level format: {PRICE[63:0], QUANTITY[15:0], NUM_ORDERS[7:0]}; all-zero = empty level.
//  - Reset: out_valid=0, out_last=0, out_data=0, busy=0, coalesced_cnt=0, seq=0, pending=0,
//    shadow image all zero (empty book), snapshot all zero.
//  - FSM IDLE -> CAPTURE -> SCAN -> {WORD0 -> WORD1 -> SCAN} -> TRAILER -> IDLE.
//  - IDLE: orderbook_ready=1 -> CAPTURE. CAPTURE (1 cycle): snapshot <= inputs, idx <= 0 -> SCAN.
//  - SCAN: one index per cycle; idx 0..DEPTH-1 = bids, DEPTH..2*DEPTH-1 = asks.
//    snapshot[idx] != shadow[idx] -> WORD0; otherwise idx++.
//    After the last idx: -> TRAILER if >=1 level emitted this burst, else IDLE.
//  - WORD0 = {side(1: 0=bid,1=ask), 3'b0, level[3:0], NUM_ORDERS[7:0], QUANTITY[15:0], 32'b0}.
//    WORD1 = PRICE[63:0]. On WORD1 acceptance, shadow[idx] <= snapshot[idx], idx++ -> SCAN.
//  - TRAILER = {8'hFF, seq[23:0], SECURITY_ID[31:0]}, out_last=1. On acceptance, seq++ (wraps at 2^24).
//  - Latency: pulse at cycle T -> CAPTURE at T+1 -> earliest out_valid at T+3 (bid level 0 changed).
//  - Handshake: out_data and out_last are registered; they hold stable while out_valid && !out_ready.
//    out_valid never drops without acceptance. Backpressure of any length stalls the FSM without loss.
//  - orderbook_ready while busy: set pending and increment coalesced_cnt (saturates at 16'hFFFF).
//    In IDLE with pending set: clear pending and go to CAPTURE (re-samples the latest book, because
//    Order_Book outputs are held). A pulse in the same cycle IDLE exits does not count as coalesced.
//  - The input is sampled only in CAPTURE; input changes at any other time are ignored.
//  - Reset asserted mid-burst: all state returns to its reset value. The next update republishes every
//    non-empty level.
//  - A level that becomes empty is published as WORD0/WORD1 with zero fields.
// STRUCTURE
//  - md_book_pkg: level_t struct (price/qty/norders), SIDE_BID/SIDE_ASK, TRAILER_TAG=8'hFF, state enum,
//    pack_word0() function.
//  - Sub-module md_out_slice: 64+1-bit valid/ready output register. Holds data under backpressure and
//    gives full throughput.
//  - Storage: snapshot and shadow as 2*DEPTH x 88 registers. Compare one entry per cycle; no wide
//    parallel comparator.
// TESTING
//  1 Reset, then pulse with bid0={64'd174,16'd9,8'd1}, rest zero, out_ready=1 ->
//    words {0,0,0,1,9,0}, 174, trailer 64'hFF000000_0000007B (last=1). No further output.
//  2 Repeat the same book -> no words, busy high 2*DEPTH+1 cycles, then IDLE.
//  3 Change ask3 qty to 5 and bid0 to empty -> bid0 WORD0/WORD1 (zeros) first, then ask3
//    (side=1, level=3), trailer seq=1.
//  4 out_ready held low 7 cycles during WORD1 -> out_data stable, no duplicate or missing word on release.
//  5 Two pulses while busy -> coalesced_cnt=2; exactly one extra burst reflects the latest book.
//  6 Assert reset_n=0 between WORD0 and WORD1 -> outputs zero immediately. The next pulse republishes
//    all non-empty levels with seq=0.

Source files
------------

// File: rtl/md_book_pkg.sv
// Shared types for the book delta publisher: level layout, sides, FSM states, word packing.
// Imported by the publisher top level.
package md_book_pkg;

    typedef struct packed {
        logic [63:0] price;
        logic [15:0] qty;
        logic [7:0]  norders;
    } level_t;

    localparam logic       SIDE_BID    = 1'b0;
    localparam logic       SIDE_ASK    = 1'b1;
    localparam logic [7:0] TRAILER_TAG = 8'hFF;

    // Wide enough for 2*DEPTH entries at the maximum DEPTH of 16.
    localparam int IDX_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SCAN,
        ST_WORD0,
        ST_WORD1,
        ST_TRAILER
    } state_t;

    function automatic logic [63:0] pack_word0(input logic side, input logic [3:0] lvl,
                                               input level_t l);
        return {side, 3'b000, lvl, l.norders, l.qty, 32'h0};
    endfunction

endpackage

// File: rtl/book_delta_publisher_if.sv
// Outbound 64-bit delta stream with an end-of-burst flag.
// master drives data/valid/last, slave drives ready.
interface book_delta_publisher_if;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/md_out_slice.sv
// Purpose: single register stage for a valid/ready stream carrying data plus a last flag.
// Latency: 1 cycle from in_vld && in_rdy to out_vld.
// Backpressure: holds out_dat/out_last while stalled; refills in the cycle the held word leaves.
module md_out_slice #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    input  logic         in_last,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_last
);

    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat  <= in_dat;
                out_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/book_delta_publisher.sv
// Purpose: on each book update, publish only levels that differ from the last published image, then a trailer.
// Latency: update pulse at T, earliest out_valid at T+3; one level compared per cycle.
// Backpressure: FSM stalls on out_ready low with no loss; pulses arriving while busy coalesce into one rescan.
module book_delta_publisher
    import md_book_pkg::*;
#(
    parameter logic [31:0] SECURITY_ID = 32'd123,
    parameter int          DEPTH       = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    orderbook_ready,
    input  logic [DEPTH*88-1:0]     bid_levels,
    input  logic [DEPTH*88-1:0]     ask_levels,
    book_delta_publisher_if.master  out,
    output logic                    busy,
    output logic [15:0]             coalesced_cnt
);

    localparam int               NLEV     = 2 * DEPTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLEV - 1);
    localparam logic [IDX_W-1:0] ASK_BASE = IDX_W'(DEPTH);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [23:0]      seq;
    logic             pending;
    logic             emitted;
    level_t           snapshot [NLEV];
    level_t           shadow   [NLEV];

    level_t           cur;
    logic             differs;
    logic             is_ask;
    logic [3:0]       lvl;
    logic             push_vld;
    logic             push_rdy;
    logic [63:0]      push_dat;
    logic             push_last;
    logic [63:0]      trailer_word;
    logic             slice_vld;
    logic [63:0]      slice_dat;
    logic             slice_last;
    logic             out_acc;

    assign trailer_word  = {TRAILER_TAG, seq, SECURITY_ID};
    assign out_acc       = slice_vld && out.out_ready;
    assign out.out_valid = slice_vld;
    assign out.out_data  = slice_dat;
    assign out.out_last  = slice_last;

    // The output register is always empty when SCAN pushes, so SCAN never has to wait on push_rdy.
    always_comb begin
        cur       = snapshot[idx];
        differs   = (cur != shadow[idx]);
        is_ask    = (idx >= ASK_BASE);
        lvl       = 4'(is_ask ? idx - ASK_BASE : idx);
        push_vld  = 1'b0;
        push_dat  = '0;
        push_last = 1'b0;
        case (state)
            ST_SCAN: begin
                if (differs) begin
                    push_vld = 1'b1;
                    push_dat = pack_word0(is_ask ? SIDE_ASK : SIDE_BID, lvl, cur);
                end else if (idx == LAST_IDX && emitted) begin
                    push_vld  = 1'b1;
                    push_dat  = trailer_word;
                    push_last = 1'b1;
                end
            end
            ST_WORD0: begin
                push_vld = 1'b1;
                push_dat = cur.price;
            end
            ST_WORD1: begin
                if (out_acc && idx == LAST_IDX) begin
                    push_vld  = 1'b1;
                    push_dat  = trailer_word;
                    push_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            idx           <= '0;
            seq           <= '0;
            pending       <= 1'b0;
            emitted       <= 1'b0;
            coalesced_cnt <= '0;
            for (int i = 0; i < NLEV; i++) begin
                snapshot[i] <= '0;
                shadow[i]   <= '0;
            end
        end else begin
            if (orderbook_ready && state != ST_IDLE) begin
                pending <= 1'b1;
                if (coalesced_cnt != 16'hFFFF) coalesced_cnt <= coalesced_cnt + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (orderbook_ready || pending) begin
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        snapshot[i]         <= bid_levels[88*i +: 88];
                        snapshot[DEPTH + i] <= ask_levels[88*i +: 88];
                    end
                    idx     <= '0;
                    emitted <= 1'b0;
                    state   <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (differs) begin
                        emitted <= 1'b1;
                        state   <= ST_WORD0;
                    end else if (idx == LAST_IDX) begin
                        busy  <= emitted;
                        state <= emitted ? ST_TRAILER : ST_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_WORD0: begin
                    if (push_rdy) state <= ST_WORD1;
                end
                ST_WORD1: begin
                    // Last level goes straight to TRAILER; the trailer was pushed alongside this acceptance.
                    if (out_acc) begin
                        shadow[idx] <= cur;
                        if (idx == LAST_IDX) begin
                            state <= ST_TRAILER;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (out_acc) begin
                        seq   <= seq + 24'd1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    md_out_slice #(.W(64)) u_out_slice (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_vld   (push_vld),
        .in_rdy   (push_rdy),
        .in_dat   (push_dat),
        .in_last  (push_last),
        .out_vld  (slice_vld),
        .out_rdy  (out.out_ready),
        .out_dat  (slice_dat),
        .out_last (slice_last)
    );

endmodule
